button_debouncer: RTL and testbench

//  Front-end conditioning for the four Genius colour buttons (green, red, blue, yellow).

---
 rtl/button_debouncer_pkg.sv | 19 +
 rtl/button_debouncer_if.sv | 37 +++
 rtl/button_debouncer_channel.sv | 50 +++++
 rtl/button_debouncer.sv | 41 ++++
 tb/tb_button_debouncer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the Genius button front end: button indices and
// the clock-derived default debounce window.
package genius_pkg;

  typedef enum logic [1:0] {
    BTN_GREEN  = 2'd0,
    BTN_RED    = 2'd1,
    BTN_BLUE   = 2'd2,
    BTN_YELLOW = 2'd3
  } btn_color_e;

  localparam int NUM_BTNS    = 4;
  localparam int CLK_FREQ_HZ = 50_000_000;
  localparam int DEBOUNCE_MS = 10;

  // 10 ms at 50 MHz gives 500_000 cycles
  localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/button_debouncer_if.sv
// Raw pad inputs and debounced levels for the four colour buttons.
// The master side drives the pads and reads the levels; the debouncer is the slave.
interface button_debouncer_if;

  logic btn_green_raw;
  logic btn_red_raw;
  logic btn_blue_raw;
  logic btn_yellow_raw;

  logic btn_green;
  logic btn_red;
  logic btn_blue;
  logic btn_yellow;

  modport master (
    output btn_green_raw,
    output btn_red_raw,
    output btn_blue_raw,
    output btn_yellow_raw,
    input  btn_green,
    input  btn_red,
    input  btn_blue,
    input  btn_yellow
  );

  modport slave (
    input  btn_green_raw,
    input  btn_red_raw,
    input  btn_blue_raw,
    input  btn_yellow_raw,
    output btn_green,
    output btn_red,
    output btn_blue,
    output btn_yellow
  );

endinterface

// File: rtl/button_debouncer_channel.sv
// One debounce channel: multi-stage synchroniser, polarity normalisation,
// persistence counter and the registered stable level.
module debounce_channel
  import genius_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SYNC_STAGES     = 2,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_level;
  logic [CNT_W-1:0]       cnt;

  // Shift the asynchronous pad through the synchroniser; reset loads the released pad level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{BTN_ACTIVE_LOW}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign sync_level = sync_q[SYNC_STAGES-1] ^ BTN_ACTIVE_LOW;

  // Accept a new level only after it persists DEBOUNCE_CYCLES cycles in a row; any bounce restarts the count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_level == level) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      level <= sync_level;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Four independent debounce channels, one per Genius colour button.
// The top only maps interface signals onto the channel array.
module button_debouncer
  import genius_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SYNC_STAGES     = 2,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  button_debouncer_if.slave bus
);

  logic [NUM_BTNS-1:0] raw_vec;
  logic [NUM_BTNS-1:0] level_vec;

  assign raw_vec[BTN_GREEN]  = bus.btn_green_raw;
  assign raw_vec[BTN_RED]    = bus.btn_red_raw;
  assign raw_vec[BTN_BLUE]   = bus.btn_blue_raw;
  assign raw_vec[BTN_YELLOW] = bus.btn_yellow_raw;

  assign bus.btn_green  = level_vec[BTN_GREEN];
  assign bus.btn_red    = level_vec[BTN_RED];
  assign bus.btn_blue   = level_vec[BTN_BLUE];
  assign bus.btn_yellow = level_vec[BTN_YELLOW];

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES),
      .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw_vec[i]),
      .level (level_vec[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer with a 4-cycle window,
// 2 synchroniser stages and active-low pads.
module tb_button_debouncer;

  localparam int D  = 4;
  localparam int S  = 2;
  localparam bit AL = 1'b1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] raw = 4'b0000;

  int checks = 0;
  int errors = 0;

  string names [4] = '{"green", "red", "blue", "yellow"};

  button_debouncer_if bus ();

  assign bus.btn_green_raw  = raw[0];
  assign bus.btn_red_raw    = raw[1];
  assign bus.btn_blue_raw   = raw[2];
  assign bus.btn_yellow_raw = raw[3];

  wire [3:0] dut = {bus.btn_yellow, bus.btn_blue, bus.btn_red, bus.btn_green};

  button_debouncer #(
    .DEBOUNCE_CYCLES (D),
    .SYNC_STAGES     (S),
    .BTN_ACTIVE_LOW  (AL)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: remember the pressed level seen at every edge; a level is accepted once the
  // D most recent samples visible past the synchroniser all disagree with the current output
  logic [S+D-1:0] hist [4];
  logic [3:0]     model_out;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (!rst_n) begin
        hist[b]      <= '0;
        model_out[b] <= 1'b0;
      end else begin
        hist[b] <= {hist[b][S+D-2:0], raw[b] ^ AL};
        if (hist[b][S-1 +: D] == {D{~model_out[b]}})
          model_out[b] <= ~model_out[b];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    rst_n = 1'b0;
    raw   = 4'b0000;
    repeat (3) tick();
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (dut[b] !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold %s got %b want 0", names[b], dut[b]);
      end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      exp = (e == 6) ? 4'b1111 : 4'b0000;
      checks++;
      if (dut !== exp) begin
        errors++;
        $display("FAIL reset_release edge %0d got %b want %b", e, dut, exp);
      end
    end
    raw = 4'b1111;
    repeat (8) begin
      tick();
      checks++;
      if (dut !== model_out) begin
        errors++;
        $display("FAIL reset_unpress got %b want %b", dut, model_out);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] exp;
    raw[0] = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      exp = (e == 6) ? 4'b0001 : 4'b0000;
      checks++;
      if (dut !== exp) begin
        errors++;
        $display("FAIL clean_press edge %0d got %b want %b", e, dut, exp);
      end
    end
    raw = 4'b1111;
    repeat (8) begin
      tick();
      checks++;
      if (dut !== model_out) begin
        errors++;
        $display("FAIL clean_release got %b want %b", dut, model_out);
      end
    end
    checks++;
    if (dut !== 4'b0000) begin
      errors++;
      $display("FAIL clean_release_final got %b want 0000", dut);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] exp;
    for (int k = 0; k < 4; k++) begin
      raw[1] = k[0];
      repeat (2) begin
        tick();
        checks++;
        if (dut[1] !== 1'b0 || dut !== model_out) begin
          errors++;
          $display("FAIL bounce_toggle got %b want red 0 model %b", dut, model_out);
        end
      end
    end
    raw[1] = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      exp = (e == 6) ? 4'b0010 : 4'b0000;
      checks++;
      if (dut !== exp) begin
        errors++;
        $display("FAIL bounce_settle edge %0d got %b want %b", e, dut, exp);
      end
    end
    raw = 4'b1111;
    repeat (8) tick();
  endtask

  task automatic test_glitch();
    raw[2] = 1'b0;
    repeat (3) begin
      tick();
      checks++;
      if (dut[2] !== 1'b0) begin
        errors++;
        $display("FAIL glitch_low %s got %b want 0", names[2], dut[2]);
      end
    end
    raw[2] = 1'b1;
    repeat (8) begin
      tick();
      checks++;
      if (dut[2] !== 1'b0 || dut !== model_out) begin
        errors++;
        $display("FAIL glitch_after got %b want blue 0 model %b", dut, model_out);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp;
    raw[3] = 1'b0;
    repeat (8) tick();
    checks++;
    if (dut !== 4'b1000) begin
      errors++;
      $display("FAIL simul_yellow_held got %b want 1000", dut);
    end
    raw = 4'b1100;
    for (int e = 1; e <= 6; e++) begin
      tick();
      exp = (e == 6) ? 4'b0011 : 4'b1000;
      checks++;
      if (dut !== exp) begin
        errors++;
        $display("FAIL simul_swap edge %0d got %b want %b", e, dut, exp);
      end
    end
    raw = 4'b1111;
    repeat (8) tick();
    checks++;
    if (dut !== 4'b0000) begin
      errors++;
      $display("FAIL simul_release got %b want 0000", dut);
    end
  endtask

  task automatic test_reset_mid_count();
    logic [3:0] exp;
    raw[2] = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    repeat (2) begin
      tick();
      checks++;
      if (dut !== 4'b0000) begin
        errors++;
        $display("FAIL midreset_hold got %b want 0000", dut);
      end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      exp = (e == 6) ? 4'b0100 : 4'b0000;
      checks++;
      if (dut !== exp) begin
        errors++;
        $display("FAIL midreset_release edge %0d got %b want %b", e, dut, exp);
      end
    end
    raw = 4'b1111;
    repeat (8) tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 4) == 0) raw[b] = ~raw[b];
      if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      tick();
      for (int b = 0; b < 4; b++) begin
        checks++;
        if (dut[b] !== model_out[b]) begin
          errors++;
          $display("FAIL random cycle %0d %s got %b want %b", n, names[b], dut[b], model_out[b]);
        end
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid_count();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
